serializador_4a1: RTL and testbench

SERIALIZADOR_4A1 -- requirements
Module: serializador_4a1

---
 rtl/serializador_4a1.sv | 121 ++++++++++++
 tb/tb_serializador_4a1.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serializador_4a1.sv
// serializador_4a1: serializes a 4-lane word from the recirculador into one
// byte per cycle, skipping lanes whose valid flag was clear at capture.
// Optional feature macro: SERIALIZADOR_PARIDAD_EN adds paridadOut, the even
// parity of dataOut (0 while validOut is low).
module serializador_4a1 #(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic [BITS-1:0] dataIn0,
  input  logic [BITS-1:0] dataIn1,
  input  logic [BITS-1:0] dataIn2,
  input  logic [BITS-1:0] dataIn3,
  input  logic            validIn0,
  input  logic            validIn1,
  input  logic            validIn2,
  input  logic            validIn3,
  output logic            readyOut,
  output logic [BITS-1:0] dataOut,
  output logic            validOut,
  output logic [1:0]      laneOut,
  input  logic            readyIn
`ifdef SERIALIZADOR_PARIDAD_EN
  ,
  output logic            paridadOut
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, stateNext;
  logic [3:0]             mask, maskNext;
  logic [3:0][BITS-1:0]   holdData, holdDataNext;

  logic [3:0]             validMask;
  logic [1:0]             lane;
  logic [3:0]             maskAfter;
  logic                   lastPending;
  logic                   consume;
  logic                   accept;

  assign validMask = {validIn3, validIn2, validIn1, validIn0};

  // Lowest-index pending lane and the mask left once it is consumed.
  always_comb begin
    lane = '0;
    casez (mask)
      4'b???1: lane = 2'd0;
      4'b??10: lane = 2'd1;
      4'b?100: lane = 2'd2;
      4'b1000: lane = 2'd3;
      default: lane = 2'd0;
    endcase
    maskAfter   = mask & ~(4'b0001 << lane);
    lastPending = (maskAfter == '0);
  end

  // State and holding register; reset discards any pending bytes.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= IDLE;
      mask     <= '0;
      holdData <= '0;
    end else begin
      state    <= stateNext;
      mask     <= maskNext;
      holdData <= holdDataNext;
    end
  end

  // Next-state and output decode. readyOut is gated by reset_L so it drops
  // immediately on reset rather than after the state register clears.
  always_comb begin
    stateNext    = state;
    maskNext     = mask;
    holdDataNext = holdData;
    readyOut     = 1'b0;
    validOut     = 1'b0;
    dataOut      = '0;
    laneOut      = '0;
    consume      = 1'b0;
    accept       = 1'b0;

    case (state)
      IDLE: begin
        readyOut = reset_L;
      end
      SEND: begin
        validOut = 1'b1;
        dataOut  = holdData[lane];
        laneOut  = lane;
        readyOut = reset_L & lastPending & readyIn;
        consume  = readyIn;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    accept = readyOut & (|validMask);

    if (accept) begin
      stateNext    = SEND;
      maskNext     = validMask;
      holdDataNext = {dataIn3, dataIn2, dataIn1, dataIn0};
    end else if (consume) begin
      maskNext = maskAfter;
      if (lastPending) begin
        stateNext = IDLE;
      end
    end
  end

`ifdef SERIALIZADOR_PARIDAD_EN
  // Even parity of the presented byte, forced low when nothing is valid.
  always_comb begin
    paridadOut = validOut & (^dataOut);
  end
`endif

endmodule

// File: tb/tb_serializador_4a1.sv
// Directed self-checking bench for serializador_4a1.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serializador_4a1;

  localparam int unsigned BITS = 8;

  logic            clk = 1'b0;
  logic            reset_L;
  logic [BITS-1:0] dataIn0, dataIn1, dataIn2, dataIn3;
  logic            validIn0, validIn1, validIn2, validIn3;
  logic            readyOut;
  logic [BITS-1:0] dataOut;
  logic            validOut;
  logic [1:0]      laneOut;
  logic            readyIn;
`ifdef SERIALIZADOR_PARIDAD_EN
  logic            paridadOut;
`endif

  int checks = 0;
  int errors = 0;

  serializador_4a1 #(.BITS(BITS)) dut (
    .clk(clk),
    .reset_L(reset_L),
    .dataIn0(dataIn0),
    .dataIn1(dataIn1),
    .dataIn2(dataIn2),
    .dataIn3(dataIn3),
    .validIn0(validIn0),
    .validIn1(validIn1),
    .validIn2(validIn2),
    .validIn3(validIn3),
    .readyOut(readyOut),
    .dataOut(dataOut),
    .validOut(validOut),
    .laneOut(laneOut),
    .readyIn(readyIn)
`ifdef SERIALIZADOR_PARIDAD_EN
    ,
    .paridadOut(paridadOut)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the presented byte: valid flag, data and lane.
  task automatic chkOut(input string tag, input logic v, input logic [7:0] d, input logic [1:0] l);
    chk({tag, ".valid"}, 32'(validOut), 32'(v));
    chk({tag, ".data"},  32'(dataOut),  32'(d));
    chk({tag, ".lane"},  32'(laneOut),  32'(l));
  endtask

  task automatic drive(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [7:0] d3, input logic [3:0] v);
    dataIn0 = d0; dataIn1 = d1; dataIn2 = d2; dataIn3 = d3;
    {validIn3, validIn2, validIn1, validIn0} = v;
  endtask

  initial begin
    reset_L = 1'b0;
    readyIn = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

    // Reset state
    #2;
    chkOut("rst", 1'b0, 8'h00, 2'd0);
    chk("rst.ready", 32'(readyOut), 32'd0);
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    chk("idle.ready", 32'(readyOut), 32'd1);

    // All-zero valid mask is not accepted
    drive(8'h55, 8'h55, 8'h55, 8'h55, 4'b0000);
    @(negedge clk);
    chkOut("noValid", 1'b0, 8'h00, 2'd0);

    // Full word
    drive(8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'b1111);
    @(negedge clk);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    chkOut("full0", 1'b1, 8'hFF, 2'd0);
    chk("full0.ready", 32'(readyOut), 32'd0);
    @(negedge clk);
    chkOut("full1", 1'b1, 8'hEE, 2'd1);
`ifdef SERIALIZADOR_PARIDAD_EN
    chk("parEE", 32'(paridadOut), 32'd0);
`endif
    @(negedge clk);
    chkOut("full2", 1'b1, 8'hDD, 2'd2);
    @(negedge clk);
    chkOut("full3", 1'b1, 8'hCC, 2'd3);
    chk("full3.ready", 32'(readyOut), 32'd1);
    @(negedge clk);
    chkOut("fullEnd", 1'b0, 8'h00, 2'd0);

    // Sparse mask: lanes 1 and 3 only
    drive(8'hBB, 8'hAA, 8'h99, 8'h88, 4'b1010);
    @(negedge clk);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    chkOut("sparse0", 1'b1, 8'hAA, 2'd1);
    @(negedge clk);
    chkOut("sparse1", 1'b1, 8'h88, 2'd3);
    @(negedge clk);
    chkOut("sparseEnd", 1'b0, 8'h00, 2'd0);

    // Back-pressure, inputs ignored while not ready, then back-to-back reload
    drive(8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'b1111);
    @(negedge clk);
    chkOut("bp0", 1'b1, 8'hFF, 2'd0);
    readyIn = 1'b0;
    drive(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkOut("bpHold", 1'b1, 8'hFF, 2'd0);
      chk("bpHold.ready", 32'(readyOut), 32'd0);
      if (i == 0) drive(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    end
    readyIn = 1'b1;
    @(negedge clk);
    chkOut("bp1", 1'b1, 8'hEE, 2'd1);
    @(negedge clk);
    chkOut("bp2", 1'b1, 8'hDD, 2'd2);
    @(negedge clk);
    chkOut("bp3", 1'b1, 8'hCC, 2'd3);
    drive(8'h00, 8'h00, 8'h77, 8'h00, 4'b0100);
    #1;
    chk("b2b.ready", 32'(readyOut), 32'd1);
    @(negedge clk);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    chkOut("b2b", 1'b1, 8'h77, 2'd2);
    @(negedge clk);
    chkOut("b2bEnd", 1'b0, 8'h00, 2'd0);

    // Reset mid-word after EE is consumed
    drive(8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'b1111);
    @(negedge clk);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    chkOut("mid0", 1'b1, 8'hFF, 2'd0);
    @(negedge clk);
    chkOut("mid1", 1'b1, 8'hEE, 2'd1);
    @(posedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    chkOut("asyncRst", 1'b0, 8'h00, 2'd0);
    chk("asyncRst.ready", 32'(readyOut), 32'd0);
    @(negedge clk);
    reset_L = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkOut("postRst", 1'b0, 8'h00, 2'd0);
    end

    // First accept right after a reset release
    @(negedge clk);
    reset_L = 1'b0;
    #1;
    reset_L = 1'b1;
    drive(8'h07, 8'h00, 8'h00, 8'h00, 4'b0001);
    #1;
    chk("relAccept.ready", 32'(readyOut), 32'd1);
    @(negedge clk);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    chkOut("rel07", 1'b1, 8'h07, 2'd0);
`ifdef SERIALIZADOR_PARIDAD_EN
    chk("par07", 32'(paridadOut), 32'd1);
`endif
    @(negedge clk);
    chkOut("relEnd", 1'b0, 8'h00, 2'd0);
`ifdef SERIALIZADOR_PARIDAD_EN
    chk("parIdle", 32'(paridadOut), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
